// File: rtl/dmem_lsu_ctl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : dmem_lsu_ctl
// Brief  : MEM-stage load/store controller: byte-lane steering, load
//          extension, misalignment/IO filtering and req/ack memory port.
//          Optional macro LSU_TIMEOUT_EN adds a MAX_WAIT abort counter.
// Rev    : 1.0
//----------------------------------------------------------------------------
module dmem_lsu_ctl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int IO_BIT   = 31,
   parameter int MAX_WAIT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            req_ctl,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  stall_o,
   output logic [31:0]           ld_data_o,
   output logic                  ld_valid_o,
   output logic                  misalign_o,
   output logic [ADDR_W-1:0]     bad_addr_o,
   output logic                  timeout_o,
   output logic                  mem_req_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W/8-1:0]   mem_we_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   input  logic                  mem_ack_i
);
   localparam int LANES = DATA_W / 8;
   localparam int LB    = $clog2(LANES);
   localparam int SHW   = LB + 3;
   localparam logic [SHW-1:0] SH_HALF = SHW'(8);
   localparam logic [SHW-1:0] SH_WORD = SHW'(24);

   localparam logic [3:0] DMEM_NOP = 4'd0;
   localparam logic [3:0] DMEM_SB  = 4'd1;
   localparam logic [3:0] DMEM_SH  = 4'd2;
   localparam logic [3:0] DMEM_SW  = 4'd3;
   localparam logic [3:0] DMEM_LBS = 4'd4;
   localparam logic [3:0] DMEM_LBU = 4'd5;
   localparam logic [3:0] DMEM_LHS = 4'd6;
   localparam logic [3:0] DMEM_LHU = 4'd7;
   localparam logic [3:0] DMEM_LW  = 4'd8;

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [3:0]          ctl_q, ctl_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LANES-1:0]    we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [31:0]         ld_data_q, ld_data_d;
   logic                ld_valid_q, ld_valid_d;
   logic                misalign_q, misalign_d;
   logic                timeout_q, timeout_d;
   logic [ADDR_W-1:0]   bad_addr_q, bad_addr_d;

   logic                req_ld, req_st, req_mis, req_io;
   logic [2:0]          req_sz;
   logic [LB-1:0]       req_b, cur_b;
   logic [LANES-1:0]    we_new;
   logic [DATA_W-1:0]   wdata_new;
   logic [SHW-1:0]      sh_byte, sh_sel;
   logic [31:0]         fld, ld_fmt;
   logic                cur_ld, abort, take_new;

   // Request decode (unlisted codes behave as NOP)
   always_comb begin
      req_ld = 1'b0;
      req_st = 1'b0;
      req_sz = 3'd0;
      case (req_ctl)
         DMEM_SB:            begin req_st = 1'b1; req_sz = 3'd1; end
         DMEM_SH:            begin req_st = 1'b1; req_sz = 3'd2; end
         DMEM_SW:            begin req_st = 1'b1; req_sz = 3'd4; end
         DMEM_LBS, DMEM_LBU: begin req_ld = 1'b1; req_sz = 3'd1; end
         DMEM_LHS, DMEM_LHU: begin req_ld = 1'b1; req_sz = 3'd2; end
         DMEM_LW:            begin req_ld = 1'b1; req_sz = 3'd4; end
         default:            ;
      endcase
   end

   assign req_b   = req_addr[LB-1:0];
   assign req_mis = ((req_sz == 3'd2) && req_b[0]) ||
                    ((req_sz == 3'd4) && (req_b[1:0] != 2'b00));
   assign req_io  = req_addr[IO_BIT];

   always_comb begin
      we_new = '0;
      for (int l = 0; l < LANES; l++) begin
         if (req_st && (l >= int'(req_b)) && (l < int'(req_b) + int'(req_sz)))
            we_new[LANES-1-l] = 1'b1;
      end
      case (req_sz)
         3'd1:    wdata_new = {LANES{req_wdata[7:0]}};
         3'd2:    wdata_new = {(LANES/2){req_wdata[15:0]}};
         default: wdata_new = {(LANES/4){req_wdata}};
      endcase
   end

   // Lane b sits 8*(LANES-1-b) bits above bit 0; wider fields start lower
   assign cur_b  = addr_q[LB-1:0];
   assign cur_ld = (ctl_q == DMEM_LBS) || (ctl_q == DMEM_LBU) || (ctl_q == DMEM_LHS) ||
                   (ctl_q == DMEM_LHU) || (ctl_q == DMEM_LW);

   always_comb begin
      sh_byte = {~cur_b, 3'b000};
      case (ctl_q)
         DMEM_LHS, DMEM_LHU: sh_sel = sh_byte - SH_HALF;
         DMEM_LW:            sh_sel = sh_byte - SH_WORD;
         default:            sh_sel = sh_byte;
      endcase
      fld = 32'(mem_rdata_i >> sh_sel);
      case (ctl_q)
         DMEM_LBS: ld_fmt = {{24{fld[7]}}, fld[7:0]};
         DMEM_LBU: ld_fmt = {24'd0, fld[7:0]};
         DMEM_LHS: ld_fmt = {{16{fld[15]}}, fld[15:0]};
         DMEM_LHU: ld_fmt = {16'd0, fld[15:0]};
         default:  ld_fmt = fld;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam int CW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   assign abort = (state_q == BUSY) && !mem_ack_i && (cnt_q == CW'(MAX_WAIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == BUSY && !mem_ack_i && !abort)
         cnt_d = cnt_q + CW'(1);
      if (take_new && (req_ld || req_st) && !req_mis && !req_io)
         cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   logic unused_max_wait;
   assign unused_max_wait = (MAX_WAIT > 0);
   assign abort           = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ctl_d      = ctl_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      ld_data_d  = ld_data_q;
      ld_valid_d = 1'b0;
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
      bad_addr_d = bad_addr_q;
      stall_o    = 1'b0;
      take_new   = 1'b0;
      case (state_q)
         IDLE: take_new = 1'b1;
         BUSY: begin
            if (mem_ack_i || abort) begin
               state_d = IDLE;
               if (cur_ld) begin
                  ld_valid_d = 1'b1;
                  ld_data_d  = abort ? 32'd0 : ld_fmt;
               end
               if (abort) begin
                  timeout_d  = 1'b1;
                  bad_addr_d = addr_q;
               end
               // An I/O load here would need the same ld_valid slot: hold it one cycle
               if (cur_ld && req_ld && req_io && !req_mis) stall_o = 1'b1;
               else                                        take_new = 1'b1;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take_new && (req_ld || req_st)) begin
         if (req_mis) begin
            misalign_d = 1'b1;
            bad_addr_d = req_addr;
         end else if (req_io) begin
            if (req_ld) begin
               ld_valid_d = 1'b1;
               ld_data_d  = 32'd0;
            end
         end else begin
            state_d = BUSY;
            ctl_d   = req_ctl;
            addr_d  = req_addr;
            we_d    = we_new;
            wdata_d = wdata_new;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ctl_q      <= DMEM_NOP;
         addr_q     <= '0;
         we_q       <= '0;
         wdata_q    <= '0;
         ld_data_q  <= '0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         timeout_q  <= 1'b0;
         bad_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ctl_q      <= ctl_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         ld_data_q  <= ld_data_d;
         ld_valid_q <= ld_valid_d;
         misalign_q <= misalign_d;
         timeout_q  <= timeout_d;
         bad_addr_q <= bad_addr_d;
      end
   end

   assign mem_req_o   = (state_q == BUSY);
   assign mem_addr_o  = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
   assign mem_we_o    = mem_req_o ? we_q : '0;
   assign mem_wdata_o = wdata_q;
   assign ld_data_o   = ld_data_q;
   assign ld_valid_o  = ld_valid_q;
   assign misalign_o  = misalign_q;
   assign bad_addr_o  = bad_addr_q;
   assign timeout_o   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctl.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module : tb_dmem_lsu_ctl
// Brief  : Scoreboard bench for dmem_lsu_ctl, 32-bit and 64-bit bus instances.
// Rev    : 1.0
//----------------------------------------------------------------------------
module tb_dmem_lsu_ctl;
   localparam logic [3:0] NOP = 4'd0, SB = 4'd1, SH = 4'd2, SW = 4'd3, LBS = 4'd4,
                          LBU = 4'd5, LHS = 4'd6, LHU = 4'd7, LW = 4'd8;

   typedef struct packed {
      logic        dut;
      logic [63:0] a;
      logic [63:0] d;
      logic [7:0]  we;
      logic        wd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  ctl32 = NOP, ctl64 = NOP;
   logic [31:0] addr32 = '0, addr64 = '0, wd32 = '0, wd64 = '0;
   logic        ack32 = 1'b0, ack64 = 1'b0;
   logic [31:0] rd32 = '0;
   logic [63:0] rd64 = '0;
   logic        stall32, ldv32, mis32, to32, mreq32;
   logic        stall64, ldv64, mis64, to64, mreq64;
   logic [31:0] ldd32, bad32, maddr32, mwd32, ldd64, bad64, maddr64;
   logic [3:0]  mwe32;
   logic [7:0]  mwe64;
   logic [63:0] mwd64;

   int   checks = 0;
   int   errors = 0;
   int   req_cnt [2];
   exp_t qacc[$], qld[$], qmis[$], qto[$];

   dmem_lsu_ctl #(.ADDR_W(32), .DATA_W(32), .IO_BIT(31), .MAX_WAIT(15)) u_dut32 (
      .clk(clk), .rst(rst), .req_ctl(ctl32), .req_addr(addr32), .req_wdata(wd32),
      .stall_o(stall32), .ld_data_o(ldd32), .ld_valid_o(ldv32), .misalign_o(mis32),
      .bad_addr_o(bad32), .timeout_o(to32), .mem_req_o(mreq32), .mem_addr_o(maddr32),
      .mem_we_o(mwe32), .mem_wdata_o(mwd32), .mem_rdata_i(rd32), .mem_ack_i(ack32));

   dmem_lsu_ctl #(.ADDR_W(32), .DATA_W(64), .IO_BIT(31), .MAX_WAIT(15)) u_dut64 (
      .clk(clk), .rst(rst), .req_ctl(ctl64), .req_addr(addr64), .req_wdata(wd64),
      .stall_o(stall64), .ld_data_o(ldd64), .ld_valid_o(ldv64), .misalign_o(mis64),
      .bad_addr_o(bad64), .timeout_o(to64), .mem_req_o(mreq64), .mem_addr_o(maddr64),
      .mem_we_o(mwe64), .mem_wdata_o(mwd64), .mem_rdata_i(rd64), .mem_ack_i(ack64));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input int d);
      checks++;
      errors++;
      $display("FAIL %s dut=%0d event with no expectation queued", nm, d);
   endtask

   function automatic exp_t mk(input int d, input logic [63:0] a, input logic [63:0] dat,
                               input logic [7:0] we, input logic wd);
      exp_t e;
      e.dut = (d != 0);
      e.a   = a;
      e.d   = dat;
      e.we  = we;
      e.wd  = wd;
      return e;
   endfunction

   // Monitor: compares every output event against the head of its queue
   task automatic mon(input int d, input logic req, input logic ack, input logic [63:0] addr,
                      input logic [7:0] we, input logic [63:0] wd, input logic ldv,
                      input logic [31:0] ldd, input logic mis, input logic [63:0] bad,
                      input logic to);
      exp_t e;
      if (req) req_cnt[d] = req_cnt[d] + 1;
      if (req && ack) begin
         if (qacc.size() == 0) unexp("acc_unexpected", d);
         else begin
            e = qacc.pop_front();
            chk("acc_dut", 64'(d), 64'(e.dut));
            chk("acc_addr", addr, e.a);
            chk("acc_we", 64'(we), 64'(e.we));
            if (e.wd) chk("acc_wdata", wd, e.d);
         end
      end
      if (ldv) begin
         if (qld.size() == 0) unexp("ld_unexpected", d);
         else begin
            e = qld.pop_front();
            chk("ld_dut", 64'(d), 64'(e.dut));
            chk("ld_data", 64'(ldd), e.d);
         end
      end
      if (mis) begin
         if (qmis.size() == 0) unexp("mis_unexpected", d);
         else begin
            e = qmis.pop_front();
            chk("mis_dut", 64'(d), 64'(e.dut));
            chk("mis_bad_addr", bad, e.a);
         end
      end
      if (to) begin
         if (qto.size() == 0) unexp("to_unexpected", d);
         else begin
            e = qto.pop_front();
            chk("to_dut", 64'(d), 64'(e.dut));
            chk("to_bad_addr", bad, e.a);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, mreq32, ack32, 64'(maddr32), 8'(mwe32), 64'(mwd32), ldv32, ldd32, mis32, 64'(bad32), to32);
      mon(1, mreq64, ack64, 64'(maddr64), mwe64, mwd64, ldv64, ldd64, mis64, 64'(bad64), to64);
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int d, input logic [3:0] c, input logic [31:0] a, input logic [31:0] w);
      if (d == 0) begin ctl32 = c; addr32 = a; wd32 = w; end
      else        begin ctl64 = c; addr64 = a; wd64 = w; end
   endtask

   function automatic logic stall_of(input int d);
      return (d == 0) ? stall32 : stall64;
   endfunction

   task automatic issue(input int d, input logic [3:0] c, input logic [31:0] a, input logic [31:0] w);
      drive(d, c, a, w);
      @(negedge clk);
      chk("accept_stall", 64'(stall_of(d)), 64'(0));
      cyc();
      drive(d, NOP, 32'd0, 32'd0);
   endtask

   // Called at the start of BUSY cycle 1; acks after `waits` wait states
   task automatic busy(input int d, input int waits, input logic [63:0] rdata);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk("wait_stall", 64'(stall_of(d)), 64'(1));
         cyc();
      end
      if (d == 0) begin ack32 = 1'b1; rd32 = rdata[31:0]; end
      else        begin ack64 = 1'b1; rd64 = rdata; end
      @(negedge clk);
      chk("ack_stall", 64'(stall_of(d)), 64'(0));
      cyc();
      ack32 = 1'b0;
      ack64 = 1'b0;
   endtask

   int r0;

   initial begin
      req_cnt[0] = 0;
      req_cnt[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 64'(stall32), 64'(0));
      chk("rst_mem_req", 64'(mreq32), 64'(0));
      chk("rst_mem_we", 64'(mwe32), 64'(0));
      chk("rst_mem_addr", 64'(maddr32), 64'(0));
      chk("rst_ld_data", 64'(ldd32), 64'(0));
      chk("rst_bad_addr", 64'(bad32), 64'(0));
      chk("rst_outs64", {mwd64[31:0], 28'd0, mreq64, ldv64, mis64, to64}, 64'(0));
      rst = 1'b1;
      cyc();

      // SB with two wait states
      qacc.push_back(mk(0, 64'h100, 64'hABABABAB, 8'h04, 1'b1));
      issue(0, SB, 32'h0000_0101, 32'h0000_00AB);
      busy(0, 2, 64'd0);
      @(negedge clk);
      chk("sb_back_idle", 64'(mreq32), 64'(0));
      cyc();

      // Byte/half/word loads and stores on the 32-bit bus
      qacc.push_back(mk(0, 64'h200, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'hFFFF_FF80, 8'h0, 1'b0));
      issue(0, LBS, 32'h0000_0200, 32'd0);
      busy(0, 0, 64'h80FF_0000);
      qacc.push_back(mk(0, 64'h200, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'h0000_0080, 8'h0, 1'b0));
      issue(0, LBU, 32'h0000_0200, 32'd0);
      busy(0, 0, 64'h80FF_0000);
      qacc.push_back(mk(0, 64'h0, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'hFFFF_8001, 8'h0, 1'b0));
      issue(0, LHS, 32'h0000_0002, 32'd0);
      busy(0, 0, 64'h1234_8001);
      qacc.push_back(mk(0, 64'h0, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'h0000_8001, 8'h0, 1'b0));
      issue(0, LHU, 32'h0000_0002, 32'd0);
      busy(0, 1, 64'h1234_8001);
      qacc.push_back(mk(0, 64'h4, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'h1234_5678, 8'h0, 1'b0));
      issue(0, LW, 32'h0000_0004, 32'd0);
      busy(0, 0, 64'h1234_5678);
      qacc.push_back(mk(0, 64'h0, 64'h1234_1234, 8'h03, 1'b1));
      issue(0, SH, 32'h0000_0002, 32'h0000_1234);
      busy(0, 1, 64'd0);
      qacc.push_back(mk(0, 64'h0, 64'h5A5A_5A5A, 8'h01, 1'b1));
      issue(0, SB, 32'h0000_0003, 32'h0000_005A);
      busy(0, 0, 64'd0);

      // Misaligned accesses, I/O region and misalign-over-I/O priority
      r0 = req_cnt[0];
      qmis.push_back(mk(0, 64'h3, 64'd0, 8'h0, 1'b0));
      issue(0, SH, 32'h0000_0003, 32'h0000_1234);
      qmis.push_back(mk(0, 64'h6, 64'd0, 8'h0, 1'b0));
      issue(0, LW, 32'h0000_0006, 32'd0);
      qld.push_back(mk(0, 64'd0, 64'd0, 8'h0, 1'b0));
      issue(0, LW, 32'h8000_0010, 32'd0);
      issue(0, SW, 32'h8000_0020, 32'h1111_2222);
      qmis.push_back(mk(0, 64'h8000_0002, 64'd0, 8'h0, 1'b0));
      issue(0, LW, 32'h8000_0002, 32'd0);
      cyc();
      chk("no_req_mis_io", 64'(req_cnt[0] - r0), 64'(0));

      // 64-bit bus: SW then back-to-back LW accepted in the ack cycle
      qacc.push_back(mk(1, 64'h0, 64'hDEADBEEF_DEADBEEF, 8'h0F, 1'b1));
      issue(1, SW, 32'h0000_0004, 32'hDEAD_BEEF);
      drive(1, LW, 32'h0000_0008, 32'd0);
      qacc.push_back(mk(1, 64'h8, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(1, 64'd0, 64'h1122_3344, 8'h0, 1'b0));
      busy(1, 1, 64'd0);
      drive(1, NOP, 32'd0, 32'd0);
      @(negedge clk);
      chk("b2b_no_gap", 64'(mreq64), 64'(1));
      chk("b2b_addr", 64'(maddr64), 64'h8);
      cyc();
      busy(1, 0, 64'h1122_3344_5566_7788);
      qacc.push_back(mk(1, 64'h8, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(1, 64'd0, 64'h5566_7788, 8'h0, 1'b0));
      issue(1, LW, 32'h0000_000C, 32'd0);
      busy(1, 0, 64'h1122_3344_5566_7788);
      qacc.push_back(mk(1, 64'h8, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(1, 64'd0, 64'h0000_0088, 8'h0, 1'b0));
      issue(1, LBU, 32'h0000_000F, 32'd0);
      busy(1, 0, 64'h1122_3344_5566_7788);
      qacc.push_back(mk(1, 64'h8, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(1, 64'd0, 64'hFFFF_8344, 8'h0, 1'b0));
      issue(1, LHS, 32'h0000_000A, 32'd0);
      busy(1, 0, 64'h1122_8344_5566_7788);

`ifdef LSU_TIMEOUT_EN
      // No ack: abort after MAX_WAIT busy cycles, late ack ignored
      qto.push_back(mk(0, 64'h40, 64'd0, 8'h0, 1'b0));
      qld.push_back(mk(0, 64'd0, 64'd0, 8'h0, 1'b0));
      issue(0, LW, 32'h0000_0040, 32'd0);
      r0 = req_cnt[0];
      repeat (16) cyc();
      chk("to_req_cycles", 64'(req_cnt[0] - r0), 64'(15));
      ack32 = 1'b1;
      cyc();
      ack32 = 1'b0;
      cyc();
`endif

      // Reset mid-BUSY together with an ack: nothing completes
      issue(0, LW, 32'h0000_0020, 32'd0);
      @(negedge clk);
      chk("mid_busy_req", 64'(mreq32), 64'(1));
      #2;
      rst   = 1'b0;
      ack32 = 1'b1;
      #1;
      chk("async_rst_req", 64'(mreq32), 64'(0));
      chk("async_rst_stall", 64'(stall32), 64'(0));
      cyc();
      ack32 = 1'b0;
      cyc();
      rst = 1'b1;
      repeat (3) cyc();
      chk("post_rst_ldv", 64'(ldv32), 64'(0));

      chk("drain", 64'(qacc.size() + qld.size() + qmis.size() + qto.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
